// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types and constants for the memory access stage
//
// Purpose: bus widths, funct3 encodings for loads/stores, the FSM state enum
// and the packed bundles exchanged with the execute stage, the register file
// write port and the data-memory bus.
package mem_access_unit_pkg;

    localparam int cXLEN       = 32;
    localparam int cRegSelBitW = 5;

    // funct3 encodings; stores reuse B/H/W
    localparam logic [2:0] cMemB  = 3'd0;
    localparam logic [2:0] cMemH  = 3'd1;
    localparam logic [2:0] cMemW  = 3'd2;
    localparam logic [2:0] cMemBU = 3'd4;
    localparam logic [2:0] cMemHU = 3'd5;

    typedef enum logic [1:0] {
        eMemIdle,
        eMemReq,
        eMemWait
    } tMemState;

    typedef struct packed {
        logic                   read;
        logic                   write;
        logic [cXLEN-1:0]       addr;
        logic [cXLEN-1:0]       data;
        logic [2:0]             opType;
        logic [cRegSelBitW-1:0] rdAddr;
    } tMemOp;

    typedef struct packed {
        logic                   dv;
        logic [cRegSelBitW-1:0] addr;
        logic [cXLEN-1:0]       data;
    } tRegOp;

    typedef struct packed {
        tMemOp memOp;
        tRegOp regOp;
    } tAluOut;

    typedef struct packed {
        logic             req;
        logic             we;
        logic [cXLEN-1:0] addr;
        logic [cXLEN-1:0] wdata;
        logic [3:0]       be;
    } tDmemReq;

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - execute-stage, data-memory and writeback signals of the memory stage
//
// Purpose: bundles every non-clock/reset signal of mem_access_unit.
// Ports:
//   iAluOut/iAluValid/oAluReady        execute-stage handshake (unit is responder)
//   oDmemReq/We/Addr/Wdata/Be          data-memory request, held until iDmemGnt
//   iDmemGnt/iDmemRvalid/iDmemRdata    data-memory response
//   oRegOp                             register-file writeback, dv is a pulse
//   oMemErr/oMemErrAddr                error pulse with offending byte address
// Modports: slave = the memory access unit, master = its surroundings.
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    tAluOut             iAluOut;
    logic               iAluValid;
    logic               oAluReady;
    logic               oDmemReq;
    logic               oDmemWe;
    logic [cXLEN-1:0]   oDmemAddr;
    logic [cXLEN-1:0]   oDmemWdata;
    logic [3:0]         oDmemBe;
    logic               iDmemGnt;
    logic               iDmemRvalid;
    logic [cXLEN-1:0]   iDmemRdata;
    tRegOp              oRegOp;
    logic               oMemErr;
    logic [cXLEN-1:0]   oMemErrAddr;

    modport slave (
        input  iAluOut, iAluValid, iDmemGnt, iDmemRvalid, iDmemRdata,
        output oAluReady, oDmemReq, oDmemWe, oDmemAddr, oDmemWdata, oDmemBe,
        output oRegOp, oMemErr, oMemErrAddr
    );

    modport master (
        output iAluOut, iAluValid, iDmemGnt, iDmemRvalid, iDmemRdata,
        input  oAluReady, oDmemReq, oDmemWe, oDmemAddr, oDmemWdata, oDmemBe,
        input  oRegOp, oMemErr, oMemErrAddr
    );

endinterface

// File: rtl/mem_access_unit_align.sv
// rtl/mem_access_unit_align.sv - combinational store formatter, load extender and access checker
//
// Purpose: pure datapath helper for mem_access_unit.
// Ports:
//   req_*     incoming request: direction, funct3, byte offset, store data
//   req_err   misaligned, illegal funct3 for the direction, or read&write both set
//   st_wdata  lane-replicated store data; st_be byte enables (0 for loads)
//   ld_*      latched load funct3/offset and returned bus word
//   ld_value  aligned and sign/zero-extended load result
module mem_access_unit_align
    import mem_access_unit_pkg::*;
(
    input  logic               req_read,
    input  logic               req_write,
    input  logic [2:0]         req_op_type,
    input  logic [1:0]         req_off,
    input  logic [cXLEN-1:0]   req_data,
    output logic               req_err,
    output logic [cXLEN-1:0]   st_wdata,
    output logic [3:0]         st_be,
    input  logic [2:0]         ld_op_type,
    input  logic [1:0]         ld_off,
    input  logic [cXLEN-1:0]   ld_rdata,
    output logic [cXLEN-1:0]   ld_value
);

    logic             legal_op;
    logic             misaligned;
    logic [cXLEN-1:0] ld_shifted;

    always_comb begin
        legal_op = 1'b0;
        if (req_write) begin
            legal_op = (req_op_type == cMemB) || (req_op_type == cMemH) || (req_op_type == cMemW);
        end else begin
            legal_op = (req_op_type == cMemB)  || (req_op_type == cMemH) || (req_op_type == cMemW) ||
                       (req_op_type == cMemBU) || (req_op_type == cMemHU);
        end

        // funct3[1:0] encodes the access size for every legal encoding
        misaligned = 1'b0;
        case (req_op_type[1:0])
            2'd1:    misaligned = req_off[0];
            2'd2:    misaligned = (req_off != 2'd0);
            default: misaligned = 1'b0;
        endcase

        req_err = (req_read && req_write) || !legal_op || misaligned;
    end

    always_comb begin
        st_wdata = req_data;
        st_be    = 4'hF;
        case (req_op_type)
            cMemB: begin
                st_wdata = {4{req_data[7:0]}};
                st_be    = 4'b0001 << req_off;
            end
            cMemH: begin
                st_wdata = {2{req_data[15:0]}};
                st_be    = 4'b0011 << req_off;
            end
            default: begin
                st_wdata = req_data;
                st_be    = 4'hF;
            end
        endcase
        if (!req_write) begin
            st_be = 4'h0;
        end
    end

    always_comb begin
        ld_shifted = ld_rdata >> {ld_off, 3'b000};
        case (ld_op_type)
            cMemB:   ld_value = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            cMemH:   ld_value = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            cMemBU:  ld_value = {24'd0, ld_shifted[7:0]};
            cMemHU:  ld_value = {16'd0, ld_shifted[15:0]};
            default: ld_value = ld_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory stage: execute result in, data-memory access, writeback out
//
// Purpose: accepts one tAluOut per handshake in IDLE. Pass-through results
// write back the next cycle; legal loads/stores run IDLE->REQ(->WAIT)->IDLE
// with a single access in flight; illegal or misaligned accesses raise a
// one-cycle error pulse and never reach the bus.
// Ports:
//   clk   core clock, rising edge
//   rstn  asynchronous active-low reset
//   mau   mem_access_unit_if.slave (execute handshake, dmem bus, writeback, error)
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    mem_access_unit_if.slave   mau
);

    tAluOut                 alu;
    tMemState               state_q, state_d;
    tDmemReq                bus_q, bus_d;
    logic [2:0]             op_type_q, op_type_d;
    logic [1:0]             off_q, off_d;
    logic [cRegSelBitW-1:0] rd_addr_q, rd_addr_d;
    tRegOp                  regop_q, regop_d;
    logic                   err_q, err_d;
    logic [cXLEN-1:0]       err_addr_q, err_addr_d;

    logic                   accept;
    logic                   is_mem;
    logic                   req_err;
    logic [cXLEN-1:0]       st_wdata;
    logic [3:0]             st_be;
    logic [cXLEN-1:0]       ld_value;

    assign alu    = mau.iAluOut;
    assign accept = (state_q == eMemIdle) && mau.iAluValid;
    assign is_mem = alu.memOp.read || alu.memOp.write;

    mem_access_unit_align u_align (
        .req_read    (alu.memOp.read),
        .req_write   (alu.memOp.write),
        .req_op_type (alu.memOp.opType),
        .req_off     (alu.memOp.addr[1:0]),
        .req_data    (alu.memOp.data),
        .req_err     (req_err),
        .st_wdata    (st_wdata),
        .st_be       (st_be),
        .ld_op_type  (op_type_q),
        .ld_off      (off_q),
        .ld_rdata    (mau.iDmemRdata),
        .ld_value    (ld_value)
    );

    // State register; reset drops the bus request without waiting for a clock
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= eMemIdle;
            bus_q      <= '0;
            op_type_q  <= '0;
            off_q      <= '0;
            rd_addr_q  <= '0;
            regop_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            bus_q      <= bus_d;
            op_type_q  <= op_type_d;
            off_q      <= off_d;
            rd_addr_q  <= rd_addr_d;
            regop_q    <= regop_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            eMemIdle: begin
                if (accept && is_mem && !req_err) begin
                    state_d = eMemReq;
                end
            end
            eMemReq: begin
                if (mau.iDmemGnt) begin
                    state_d = bus_q.we ? eMemIdle : eMemWait;
                end
            end
            eMemWait: begin
                if (mau.iDmemRvalid) begin
                    state_d = eMemIdle;
                end
            end
            default: state_d = eMemIdle;
        endcase
    end

    // Datapath registers: request latch, writeback and error pulses
    always_comb begin
        bus_d      = bus_q;
        op_type_d  = op_type_q;
        off_d      = off_q;
        rd_addr_d  = rd_addr_q;
        regop_d    = '0;
        err_d      = 1'b0;
        err_addr_d = err_addr_q;

        case (state_q)
            eMemIdle: begin
                if (accept) begin
                    if (!is_mem) begin
                        regop_d = alu.regOp;
                        if (alu.regOp.addr == '0) begin
                            regop_d.dv = 1'b0;
                        end
                    end else if (req_err) begin
                        err_d      = 1'b1;
                        err_addr_d = alu.memOp.addr;
                    end else begin
                        bus_d.req   = 1'b1;
                        bus_d.we    = alu.memOp.write;
                        bus_d.addr  = {alu.memOp.addr[cXLEN-1:2], 2'b00};
                        bus_d.wdata = st_wdata;
                        bus_d.be    = st_be;
                        op_type_d   = alu.memOp.opType;
                        off_d       = alu.memOp.addr[1:0];
                        rd_addr_d   = alu.memOp.rdAddr;
                    end
                end
            end
            eMemReq: begin
                if (mau.iDmemGnt) begin
                    bus_d.req = 1'b0;
                end
            end
            eMemWait: begin
                if (mau.iDmemRvalid) begin
                    regop_d.dv   = (rd_addr_q != '0);
                    regop_d.addr = rd_addr_q;
                    regop_d.data = ld_value;
                end
            end
            default: begin
                bus_d.req = 1'b0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        mau.oAluReady   = (state_q == eMemIdle);
        mau.oDmemReq    = bus_q.req;
        mau.oDmemWe     = bus_q.we;
        mau.oDmemAddr   = bus_q.addr;
        mau.oDmemWdata  = bus_q.wdata;
        mau.oDmemBe     = bus_q.be;
        mau.oRegOp      = regop_q;
        mau.oMemErr     = err_q;
        mau.oMemErrAddr = err_addr_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic clk;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk  (clk),
        .rstn (rstn),
        .mau  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] op,
                          input logic [4:0] rda, input logic [37:0] rop);
        tAluOut a;
        a.memOp.read   = rd;
        a.memOp.write  = wr;
        a.memOp.addr   = addr;
        a.memOp.data   = data;
        a.memOp.opType = op;
        a.memOp.rdAddr = rda;
        a.regOp        = rop;
        bus.iAluOut    = a;
    endtask

    task automatic send(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] op, input logic [4:0] rda);
        set_op(rd, wr, addr, data, op, rda, 38'd0);
        bus.iAluValid = 1'b1;
        step();
        bus.iAluValid = 1'b0;
    endtask

    // Load with immediate grant and rvalid on the following cycle
    task automatic load(input string tag, input logic [31:0] addr, input logic [31:0] waddr,
                        input logic [2:0] op, input logic [4:0] rda,
                        input logic [31:0] rdata, input logic [37:0] exp_regop);
        send(1'b1, 1'b0, addr, 32'h0, op, rda);
        chk({tag, "/req"},   64'(bus.oDmemReq),  64'(1'b1));
        chk({tag, "/we"},    64'(bus.oDmemWe),   64'(1'b0));
        chk({tag, "/addr"},  64'(bus.oDmemAddr), 64'(waddr));
        chk({tag, "/be"},    64'(bus.oDmemBe),   64'(4'h0));
        chk({tag, "/ready"}, 64'(bus.oAluReady), 64'(1'b0));
        bus.iDmemGnt = 1'b1;
        step();
        bus.iDmemGnt = 1'b0;
        chk({tag, "/req_dropped"}, 64'(bus.oDmemReq), 64'(1'b0));
        bus.iDmemRvalid = 1'b1;
        bus.iDmemRdata  = rdata;
        step();
        bus.iDmemRvalid = 1'b0;
        chk({tag, "/regop"}, 64'(bus.oRegOp), 64'(exp_regop));
        step();
        chk({tag, "/dv_pulse"}, 64'(bus.oRegOp.dv), 64'(1'b0));
        chk({tag, "/ready_again"}, 64'(bus.oAluReady), 64'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn            = 1'b0;
        bus.iAluValid   = 1'b0;
        bus.iAluOut     = '0;
        bus.iDmemGnt    = 1'b0;
        bus.iDmemRvalid = 1'b0;
        bus.iDmemRdata  = '0;
        step();
        step();
        chk("rst/req",     64'(bus.oDmemReq),    64'(1'b0));
        chk("rst/regop",   64'(bus.oRegOp),      64'(38'd0));
        chk("rst/err",     64'(bus.oMemErr),     64'(1'b0));
        chk("rst/erraddr", 64'(bus.oMemErrAddr), 64'(32'd0));
        rstn = 1'b1;
        step();
        chk("rst/ready",   64'(bus.oAluReady),   64'(1'b1));

        load("lw",    32'h100, 32'h100, cMemW,  5'd5, 32'hDEADBEEF, {1'b1, 5'd5, 32'hDEADBEEF});
        load("lb",    32'h103, 32'h100, cMemB,  5'd6, 32'h80123456, {1'b1, 5'd6, 32'hFFFFFF80});
        load("lbu",   32'h103, 32'h100, cMemBU, 5'd7, 32'h80123456, {1'b1, 5'd7, 32'h00000080});
        load("lh",    32'h102, 32'h100, cMemH,  5'd8, 32'h80123456, {1'b1, 5'd8, 32'hFFFF8012});
        load("lhu",   32'h102, 32'h100, cMemHU, 5'd9, 32'h80123456, {1'b1, 5'd9, 32'h00008012});
        load("lw_x0", 32'h300, 32'h300, cMemW,  5'd0, 32'h12345678, {1'b0, 5'd0, 32'h12345678});

        // SB with grant withheld for three request cycles
        send(1'b0, 1'b1, 32'h201, 32'h000000AB, cMemB, 5'd0);
        for (int i = 0; i < 3; i++) begin
            chk("sb/req",   64'(bus.oDmemReq),   64'(1'b1));
            chk("sb/we",    64'(bus.oDmemWe),    64'(1'b1));
            chk("sb/addr",  64'(bus.oDmemAddr),  64'(32'h200));
            chk("sb/wdata", 64'(bus.oDmemWdata), 64'(32'hABABABAB));
            chk("sb/be",    64'(bus.oDmemBe),    64'(4'b0010));
            chk("sb/ready", 64'(bus.oAluReady),  64'(1'b0));
            step();
        end
        bus.iDmemGnt = 1'b1;
        chk("sb/req_at_gnt", 64'(bus.oDmemReq), 64'(1'b1));
        step();
        bus.iDmemGnt = 1'b0;
        chk("sb/req_after_gnt",   64'(bus.oDmemReq),  64'(1'b0));
        chk("sb/ready_after_gnt", 64'(bus.oAluReady), 64'(1'b1));

        // SH with immediate grant: ready again at T0+2
        send(1'b0, 1'b1, 32'h202, 32'h1234ABCD, cMemH, 5'd0);
        chk("sh/wdata", 64'(bus.oDmemWdata), 64'(32'hABCDABCD));
        chk("sh/be",    64'(bus.oDmemBe),    64'(4'b1100));
        bus.iDmemGnt = 1'b1;
        step();
        bus.iDmemGnt = 1'b0;
        chk("sh/ready", 64'(bus.oAluReady), 64'(1'b1));
        chk("sh/req",   64'(bus.oDmemReq),  64'(1'b0));

        // Error cases
        send(1'b1, 1'b0, 32'h102, 32'h0, cMemW, 5'd3);
        chk("mis/err",     64'(bus.oMemErr),     64'(1'b1));
        chk("mis/erraddr", 64'(bus.oMemErrAddr), 64'(32'h102));
        chk("mis/req",     64'(bus.oDmemReq),    64'(1'b0));
        chk("mis/dv",      64'(bus.oRegOp.dv),   64'(1'b0));
        step();
        chk("mis/err_pulse", 64'(bus.oMemErr),   64'(1'b0));
        chk("mis/req_late",  64'(bus.oDmemReq),  64'(1'b0));
        send(1'b1, 1'b0, 32'h104, 32'h0, 3'd3, 5'd3);
        chk("op3/err",     64'(bus.oMemErr),     64'(1'b1));
        chk("op3/erraddr", 64'(bus.oMemErrAddr), 64'(32'h104));
        chk("op3/req",     64'(bus.oDmemReq),    64'(1'b0));
        send(1'b1, 1'b1, 32'h108, 32'h0, cMemW, 5'd3);
        chk("rw/err",     64'(bus.oMemErr),     64'(1'b1));
        chk("rw/erraddr", 64'(bus.oMemErrAddr), 64'(32'h108));
        chk("rw/req",     64'(bus.oDmemReq),    64'(1'b0));
        step();
        chk("rw/req_late", 64'(bus.oDmemReq), 64'(1'b0));

        // Back-to-back pass-through ops
        set_op(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 5'd0, {1'b1, 5'd7, 32'h55});
        bus.iAluValid = 1'b1;
        step();
        set_op(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 5'd0, {1'b1, 5'd0, 32'h66});
        chk("pt/regop", 64'(bus.oRegOp), 64'({1'b1, 5'd7, 32'h55}));
        step();
        bus.iAluValid = 1'b0;
        chk("pt_x0/dv",  64'(bus.oRegOp.dv), 64'(1'b0));
        chk("pt_x0/req", 64'(bus.oDmemReq),  64'(1'b0));

        // Reset while requesting drops oDmemReq without a clock edge
        send(1'b1, 1'b0, 32'h400, 32'h0, cMemW, 5'd4);
        chk("rstreq/req_before", 64'(bus.oDmemReq), 64'(1'b1));
        #2 rstn = 1'b0;
        #1 chk("rstreq/req_async", 64'(bus.oDmemReq), 64'(1'b0));
        step();
        rstn = 1'b1;
        step();

        // Reset in WAIT, then a stray rvalid must not write back
        send(1'b1, 1'b0, 32'h400, 32'h0, cMemW, 5'd4);
        bus.iDmemGnt = 1'b1;
        step();
        bus.iDmemGnt = 1'b0;
        #2 rstn = 1'b0;
        #1 chk("rstwait/req", 64'(bus.oDmemReq), 64'(1'b0));
        step();
        rstn = 1'b1;
        bus.iDmemRvalid = 1'b1;
        bus.iDmemRdata  = 32'h0000FFFF;
        step();
        bus.iDmemRvalid = 1'b0;
        chk("rstwait/dv",    64'(bus.oRegOp.dv), 64'(1'b0));
        chk("rstwait/ready", 64'(bus.oAluReady), 64'(1'b1));
        step();
        chk("rstwait/dv_late", 64'(bus.oRegOp.dv), 64'(1'b0));
        load("after_rst", 32'h500, 32'h500, cMemW, 5'd10, 32'hCAFEF00D, {1'b1, 5'd10, 32'hCAFEF00D});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
